// File: rtl/key_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    S_UP      = 2'd0,
    S_WAIT_DN = 2'd1,
    S_DOWN    = 2'd2,
    S_WAIT_UP = 2'd3
  } key_state_t;

  // 12 ms debounce and 1 s long-press at 50 MHz
  localparam int DEB_CYCLES_DEF  = 600000;
  localparam int LONG_CYCLES_DEF = 50000000;
  localparam int CNT_W_DEF       = 26;

  // Short values that keep simulations fast
  localparam int DEB_SIM  = 4;
  localparam int LONG_SIM = 20;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM, hold timer and
// registered press / release / long-press pulses.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_UP      | key accepted as released
//   S_WAIT_DN | key sampled pressed, waiting for it to stay pressed
//   S_DOWN    | key accepted as pressed (hold timer running)
//   S_WAIT_UP | key sampled released, waiting for it to stay released
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             s;
  key_state_t       state, state_nxt;
  logic [CNT_W-1:0] deb_cnt, deb_nxt;
  logic [CNT_W-1:0] long_cnt, long_nxt;
  logic             long_done, done_nxt;
  logic             level_nxt, press_nxt, release_nxt, long_pulse_nxt;

  // Bring the asynchronous key into the clock domain; idle level is released
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], i_key_n};
  end

  assign s = sync_q[1];

  // State, counters and output pulse registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_UP;
      deb_cnt   <= '0;
      long_cnt  <= '0;
      long_done <= 1'b0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
    end else begin
      state     <= state_nxt;
      deb_cnt   <= deb_nxt;
      long_cnt  <= long_nxt;
      long_done <= done_nxt;
      o_level   <= level_nxt;
      o_press   <= press_nxt;
      o_release <= release_nxt;
      o_long    <= long_pulse_nxt;
    end
  end

  // Next-state, counter and pulse decisions
  always_comb begin
    state_nxt      = state;
    deb_nxt        = deb_cnt;
    long_nxt       = long_cnt;
    done_nxt       = long_done;
    press_nxt      = 1'b0;
    release_nxt    = 1'b0;
    long_pulse_nxt = 1'b0;

    // Hold timer runs through release bounces so they never restart it
    if ((state == S_DOWN || state == S_WAIT_UP) && !long_done) begin
      if (long_cnt == LONG_LAST) begin
        long_pulse_nxt = 1'b1;
        done_nxt       = 1'b1;
      end else begin
        long_nxt = long_cnt + CNT_ONE;
      end
    end

    case (state)
      S_UP: begin
        if (!s) begin
          state_nxt = S_WAIT_DN;
          deb_nxt   = '0;
        end
      end
      S_WAIT_DN: begin
        if (s) begin
          state_nxt = S_UP;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = S_DOWN;
          press_nxt = 1'b1;
          long_nxt  = '0;
          done_nxt  = 1'b0;
        end else begin
          deb_nxt = deb_cnt + CNT_ONE;
        end
      end
      S_DOWN: begin
        if (s) begin
          state_nxt = S_WAIT_UP;
          deb_nxt   = '0;
        end
      end
      S_WAIT_UP: begin
        if (!s) begin
          state_nxt = S_DOWN;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = S_UP;
          release_nxt = 1'b1;
        end else begin
          deb_nxt = deb_cnt + CNT_ONE;
        end
      end
      default: state_nxt = S_UP;
    endcase

    level_nxt = (state_nxt == S_DOWN) || (state_nxt == S_WAIT_UP);
  end

endmodule

// File: rtl/key_conditioner.sv
// Debounces N_KEYS raw active-low push-buttons into clean level and pulse
// outputs for the recorder/player control FSM.
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS      = 3,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key_n,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic              o_any_press
);

  // Independent channels; any priority between keys is left to the consumer
  for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_key_n  (i_key_n[k]),
      .o_level  (o_level[k]),
      .o_press  (o_press[k]),
      .o_release(o_release[k]),
      .o_long   (o_long[k])
    );
  end

  assign o_any_press = |o_press;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;
  import key_pkg::*;

  localparam int N    = 3;
  localparam int DEB  = DEB_SIM;
  localparam int LONG = LONG_SIM;
  localparam int CW   = 8;
  localparam int LAT  = DEB + 2;   // edge index offset of a pulse from edge 1

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] o_level, o_press, o_release, o_long;
  logic         o_any_press;

  always #5 clk = ~clk;

  key_conditioner #(
    .N_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_n(key_n),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_any_press(o_any_press)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: a key level is accepted once the synchronized sample
  // has disagreed with the accepted level for DEB+1 consecutive edges; the
  // long pulse fires LONG edges after the press while still accepted held.
  logic [N-1:0] q1, q2, m_held, m_ldone, e_press, e_rel, e_long;
  int run [N];
  int since [N];

  // Observed statistics for directed scenario checks
  int c_press [N], c_rel [N], c_long [N];
  int last_press [N], last_rel [N], last_long [N], last_fall [N];
  int c_any;
  logic [N-1:0] first_pv, lvl_seen, prev_level;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d required %0d (edge %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    q1 = '1; q2 = '1; m_held = '0; m_ldone = '0;
    e_press = '0; e_rel = '0; e_long = '0;
    for (int k = 0; k < N; k++) begin run[k] = 0; since[k] = 0; end
    prev_level = '0;
  endtask

  task automatic clear_stats();
    for (int k = 0; k < N; k++) begin
      c_press[k] = 0; c_rel[k] = 0; c_long[k] = 0;
      last_press[k] = -1; last_rel[k] = -1; last_long[k] = -1; last_fall[k] = -1;
    end
    c_any = 0; first_pv = '0; lvl_seen = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    logic s;
    for (int k = 0; k < N; k++) begin
      s = q2[k]; q2[k] = q1[k]; q1[k] = raw[k];
      e_press[k] = 1'b0; e_rel[k] = 1'b0; e_long[k] = 1'b0;
      if (m_held[k] && !m_ldone[k]) begin
        since[k]++;
        if (since[k] == LONG) begin e_long[k] = 1'b1; m_ldone[k] = 1'b1; end
      end
      if ((s == 1'b0) != m_held[k]) run[k]++;
      else run[k] = 0;
      if (run[k] == DEB + 1) begin
        run[k] = 0;
        m_held[k] = ~m_held[k];
        if (m_held[k]) begin e_press[k] = 1'b1; since[k] = 0; m_ldone[k] = 1'b0; end
        else e_rel[k] = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic [N-1:0] k_in);
    key_n = k_in;
    @(posedge clk);
    cyc++;
    model_edge(k_in);
    @(negedge clk);
    chk("level", 32'(o_level), 32'(m_held));
    chk("press", 32'(o_press), 32'(e_press));
    chk("release", 32'(o_release), 32'(e_rel));
    chk("long", 32'(o_long), 32'(e_long));
    chk("any_press", 32'(o_any_press), 32'(|e_press));
    for (int k = 0; k < N; k++) begin
      if (o_press[k] === 1'b1) begin c_press[k]++; last_press[k] = cyc; end
      if (o_release[k] === 1'b1) begin c_rel[k]++; last_rel[k] = cyc; end
      if (o_long[k] === 1'b1) begin c_long[k]++; last_long[k] = cyc; end
      if (prev_level[k] === 1'b1 && o_level[k] === 1'b0) last_fall[k] = cyc;
    end
    if (o_any_press === 1'b1) c_any++;
    if (first_pv == '0 && o_press != '0) first_pv = o_press;
    lvl_seen |= o_level;
    prev_level = o_level;
  endtask

  task automatic apply_reset(input int edges);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_outputs_now", 32'({o_level, o_press, o_release, o_long, o_any_press}), 32'd0);
    repeat (edges) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs_held", 32'({o_level, o_press, o_release, o_long, o_any_press}), 32'd0);
    rst_n = 1'b1;
  endtask

  int c0, f;
  logic [N-1:0] rk;
  int dur [N];

  initial begin
    model_reset();
    clear_stats();

    apply_reset(3);
    repeat (3) tick('1);

    // Clean press on key 0, held 40 cycles
    clear_stats();
    c0 = cyc + 1;
    repeat (40) tick(3'b110);
    chk("clean_press_cnt", c_press[0], 1);
    chk("clean_press_edge", last_press[0], c0 + LAT);
    chk("clean_long_cnt", c_long[0], 1);
    chk("clean_long_dist", last_long[0] - last_press[0], LONG);
    chk("clean_level_held", 32'(o_level[0]), 1);

    // Release with bounce on key 0
    clear_stats();
    tick(3'b111); tick(3'b111); tick(3'b110);
    f = cyc + 1;
    repeat (12) tick(3'b111);
    chk("relb_no_press", c_press[0], 0);
    chk("relb_rel_cnt", c_rel[0], 1);
    chk("relb_rel_edge", last_rel[0], f + LAT);
    chk("relb_level_fall", last_fall[0], last_rel[0]);

    // Bounce rejection on key 1
    clear_stats();
    repeat (7) begin
      tick(3'b101); tick(3'b101); tick(3'b111); tick(3'b111);
    end
    tick(3'b101); tick(3'b101);
    repeat (10) tick(3'b111);
    chk("bounce_press", c_press[0] + c_press[1] + c_press[2], 0);
    chk("bounce_release", c_rel[0] + c_rel[1] + c_rel[2], 0);
    chk("bounce_level", 32'(lvl_seen), 0);

    // Short tap on key 2
    clear_stats();
    c0 = cyc + 1;
    repeat (10) tick(3'b011);
    repeat (15) tick(3'b111);
    chk("tap_press_cnt", c_press[2], 1);
    chk("tap_long_cnt", c_long[2], 0);
    chk("tap_rel_cnt", c_rel[2], 1);
    chk("tap_rel_edge", last_rel[2], c0 + 10 + LAT);
    chk("tap_any_cnt", c_any, 1);

    // Simultaneous presses on keys 0 and 2
    clear_stats();
    c0 = cyc + 1;
    repeat (12) tick(3'b010);
    repeat (12) tick(3'b111);
    chk("simul_vec", 32'(first_pv), 32'(3'b101));
    chk("simul_edge", last_press[0], c0 + LAT);
    chk("simul_same", last_press[2], last_press[0]);
    chk("simul_any_cnt", c_any, 1);

    // Reset while key 0 is still qualifying its press
    clear_stats();
    repeat (5) tick(3'b110);
    chk("abort_no_press", c_press[0], 0);
    apply_reset(2);
    clear_stats();
    c0 = cyc + 1;
    repeat (12) tick(3'b110);
    chk("rstmid_press_cnt", c_press[0], 1);
    chk("rstmid_press_edge", last_press[0], c0 + LAT);
    chk("rstmid_no_release", c_rel[0], 0);
    repeat (12) tick(3'b111);
    chk("rstmid_fresh_rel", c_rel[0], 1);

    // Randomized hold/glitch patterns against the model
    clear_stats();
    rk = '1;
    for (int k = 0; k < N; k++) dur[k] = $urandom_range(1, 30);
    repeat (800) begin
      for (int k = 0; k < N; k++) begin
        if (dur[k] == 0) begin
          rk[k] = ~rk[k];
          dur[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
        end
        dur[k]--;
      end
      tick(rk);
    end
    repeat (40) tick('1);
    chk("rand_settled_level", 32'(o_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
